// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA timing controller.
// Mode encoding, colour type, bar palette and delayed control bundle.
package vga_pkg;

  typedef enum logic [1:0] {
    VGA_PASS  = 2'd0,
    VGA_SOLID = 2'd1,
    VGA_BARS  = 2'd2
  } vga_mode_e;

  typedef logic [11:0] rgb12_t;

  // Control bits that must stay aligned with the fetched pixel
  typedef struct packed {
    logic      hs;
    logic      vs;
    logic      act;
    logic      first;
    vga_mode_e mode;
  } vga_ctrl_t;

  localparam rgb12_t BLANK_RGB = 12'h000;

  localparam rgb12_t BAR_PAL [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic vga_mode_e mode_decode(
    input logic [1:0] m
  );
    vga_mode_e r;
    unique case (m)
      2'd1:    r = VGA_SOLID;
      2'd2:    r = VGA_BARS;
      default: r = VGA_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_delay.sv
// vga_delay_line: enable-gated shift register with a reset value.
// A depth of zero collapses to a plain wire.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign q_o = d_i;
  end else begin : g_sr
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++)
          sr_q[i] <= RST_VAL;
      end else if (en) begin
        sr_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++)
          sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: parametrised VGA sync/blank generator and
// pixel output stage with latency-matched sync and frame modes.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_A_VID   = 640,
  parameter int unsigned H_F_PORCH = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_B_PORCH = 48,
  parameter int unsigned V_A_VID   = 480,
  parameter int unsigned V_F_PORCH = 11,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_B_PORCH = 31,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned PIX_LAT   = 2,
  localparam int unsigned H_TOT =
    H_A_VID + H_F_PORCH + H_SYNC + H_B_PORCH,
  localparam int unsigned V_TOT =
    V_A_VID + V_F_PORCH + V_SYNC + V_B_PORCH,
  localparam int unsigned HW = $clog2(H_TOT),
  localparam int unsigned VW = $clog2(V_TOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [11:0]   solid_rgb,
  input  logic [11:0]   pix_data,
  input  logic          pix_valid,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y,
  output logic          pix_req,
  output logic          pix_ce,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          frame_start,
  output logic          underflow
);

  localparam int unsigned DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  localparam int unsigned HS_BEG = H_A_VID + H_F_PORCH;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_A_VID + V_F_PORCH;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam int unsigned BAR_W  = H_A_VID / 8;

  localparam vga_ctrl_t CTRL_RST = '{
    hs:    ~H_POL,
    vs:    ~V_POL,
    act:   1'b0,
    first: 1'b0,
    mode:  VGA_PASS
  };

  logic [DW-1:0] div_q, div_d;
  logic          ce_q, ce_d;

  always_comb begin
    div_d = div_q + DW'(1);
    ce_d  = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      ce_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ce_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  logic [31:0] h_w, v_w;
  logic        hs_raw, vs_raw, act_raw, origin;

  assign h_w     = 32'(h_q);
  assign v_w     = 32'(v_q);
  assign hs_raw  = (h_w >= HS_BEG && h_w < HS_END)
                 ? H_POL : ~H_POL;
  assign vs_raw  = (v_w >= VS_BEG && v_w < VS_END)
                 ? V_POL : ~V_POL;
  assign act_raw = (h_w < H_A_VID) && (v_w < V_A_VID);
  assign origin  = (h_q == '0) && (v_q == '0);

  // Mode travels with the pixel so (0,0) already sees the new frame mode
  vga_mode_e mode_q, mode_d, mode_cur;

  assign mode_cur = origin ? mode_decode(mode) : mode_q;
  assign mode_d   = ce_q ? mode_cur : mode_q;

  always_ff @(posedge clk) begin
    if (rst) mode_q <= VGA_PASS;
    else     mode_q <= mode_d;
  end

  vga_ctrl_t ctrl_raw, ctrl_dly;

  always_comb begin
    ctrl_raw.hs    = hs_raw;
    ctrl_raw.vs    = vs_raw;
    ctrl_raw.act   = act_raw;
    ctrl_raw.first = origin;
    ctrl_raw.mode  = mode_cur;
  end

  vga_delay_line #(
    .WIDTH   ($bits(vga_ctrl_t)),
    .DEPTH   (PIX_LAT),
    .RST_VAL (CTRL_RST)
  ) u_ctrl_dly (
    .clk (clk),
    .rst (rst),
    .en  (ce_q),
    .d_i (ctrl_raw),
    .q_o (ctrl_dly)
  );

  logic [HW-1:0] h_dly;

  vga_delay_line #(
    .WIDTH   (HW),
    .DEPTH   (PIX_LAT),
    .RST_VAL ('0)
  ) u_h_dly (
    .clk (clk),
    .rst (rst),
    .en  (ce_q),
    .d_i (h_q),
    .q_o (h_dly)
  );

  logic [2:0] bar_sel;
  rgb12_t     rgb_d;
  logic       uf_d;

  assign bar_sel = 3'(32'(h_dly) / BAR_W);

  always_comb begin
    rgb_d = BLANK_RGB;
    uf_d  = 1'b0;
    if (ctrl_dly.act) begin
      unique case (ctrl_dly.mode)
        VGA_SOLID: rgb_d = solid_rgb;
        VGA_BARS:  rgb_d = BAR_PAL[bar_sel];
        default: begin
          if (pix_valid) rgb_d = pix_data;
          else           uf_d  = 1'b1;
        end
      endcase
    end
  end

  rgb12_t rgb_q;
  logic   hs_q, vs_q, act_q, fs_q, uf_q;

  // Pulses clear every clk so they last one clk, not a whole pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= BLANK_RGB;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      act_q <= 1'b0;
      fs_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      uf_q <= 1'b0;
      if (ce_q) begin
        rgb_q <= rgb_d;
        hs_q  <= ctrl_dly.hs;
        vs_q  <= ctrl_dly.vs;
        act_q <= ctrl_dly.act;
        fs_q  <= ctrl_dly.first;
        uf_q  <= uf_d;
      end
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign pix_req     = act_raw & ~rst;
  assign pix_ce      = ce_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign active      = act_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: two small-geometry instances against a
// tick-count reference model plus directed corner sequences.
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int HWB = $clog2(HT);
  localparam int VWB = $clog2(VT);

  localparam int CFG_DIV [2] = '{1, 3};
  localparam int CFG_LAT [2] = '{0, 2};
  localparam bit CFG_HP  [2] = '{1'b0, 1'b1};
  localparam bit CFG_VP  [2] = '{1'b0, 1'b1};

  localparam logic [11:0] PAL [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  logic clk = 1'b0;
  logic rst;
  logic [1:0] mode;
  logic [11:0] solid_rgb;
  logic pix_valid;
  logic [11:0] pd [2];
  logic [HWB-1:0] px [2];
  logic [VWB-1:0] py [2];
  logic preq [2], pce [2], hs [2], vs [2];
  logic act [2], fs [2], uf [2];
  logic [3:0] r [2], g [2], b [2];

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_A_VID(HA), .H_F_PORCH(HF), .H_SYNC(HS), .H_B_PORCH(HB),
    .V_A_VID(VA), .V_F_PORCH(VF), .V_SYNC(VS), .V_B_PORCH(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(1), .PIX_LAT(0)
  ) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .pix_data(pd[0]), .pix_valid(pix_valid),
    .pix_x(px[0]), .pix_y(py[0]), .pix_req(preq[0]),
    .pix_ce(pce[0]), .red(r[0]), .green(g[0]), .blue(b[0]),
    .hsync(hs[0]), .vsync(vs[0]), .active(act[0]),
    .frame_start(fs[0]), .underflow(uf[0])
  );

  vga_timing_ctrl #(
    .H_A_VID(HA), .H_F_PORCH(HF), .H_SYNC(HS), .H_B_PORCH(HB),
    .V_A_VID(VA), .V_F_PORCH(VF), .V_SYNC(VS), .V_B_PORCH(VB),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(3), .PIX_LAT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .pix_data(pd[1]), .pix_valid(pix_valid),
    .pix_x(px[1]), .pix_y(py[1]), .pix_req(preq[1]),
    .pix_ce(pce[1]), .red(r[1]), .green(g[1]), .blue(b[1]),
    .hsync(hs[1]), .vsync(vs[1]), .active(act[1]),
    .frame_start(fs[1]), .underflow(uf[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_e [2] = '{0, 0};
  int m_k [2] = '{0, 0};
  bit m_ce [2] = '{1'b0, 1'b0};
  int fmode [2][2];
  int last_fs [2] = '{-1, -1};
  logic [11:0] x_rgb [2];
  logic x_hs [2], x_vs [2], x_act [2], x_fs [2], x_uf [2];

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        act;
  } row_t;
  row_t tab [14];

  function automatic logic [11:0] fetch(int j);
    if (j < 0) return 12'hABC;
    return {4'(j % HT), 4'((j / HT) % VT), 4'h5};
  endfunction

  function automatic bit in_act(int j);
    return ((j % HT) < HA) && (((j / HT) % VT) < VA);
  endfunction

  task automatic chk(string nm, int i,
                     logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h at %0t",
               nm, i, got, exp, $time);
    end
  endtask

  // Outputs after pix_ce tick k describe raster position k - PIX_LAT
  task automatic model_edge(int i);
    int s, h, v, md;
    if (rst) begin
      m_e[i] = 0; m_k[i] = 0; m_ce[i] = 1'b0;
      last_fs[i] = -1;
      x_rgb[i] = 12'h000; x_act[i] = 1'b0;
      x_hs[i] = ~CFG_HP[i]; x_vs[i] = ~CFG_VP[i];
      x_fs[i] = 1'b0; x_uf[i] = 1'b0;
      return;
    end
    x_fs[i] = 1'b0;
    x_uf[i] = 1'b0;
    if (m_ce[i]) begin
      if (m_k[i] % FT == 0)
        fmode[i][(m_k[i] / FT) % 2] = (mode == 2'd3) ? 0 : int'(mode);
      s = m_k[i] - CFG_LAT[i];
      if (s < 0) begin
        x_rgb[i] = 12'h000; x_act[i] = 1'b0;
        x_hs[i] = ~CFG_HP[i]; x_vs[i] = ~CFG_VP[i];
      end else begin
        h = s % HT;
        v = (s / HT) % VT;
        x_act[i] = in_act(s);
        x_hs[i] = (h >= HA + HF && h < HA + HF + HS)
                ? CFG_HP[i] : ~CFG_HP[i];
        x_vs[i] = (v >= VA + VF && v < VA + VF + VS)
                ? CFG_VP[i] : ~CFG_VP[i];
        x_fs[i] = (h == 0 && v == 0);
        md = fmode[i][(s / FT) % 2];
        x_rgb[i] = 12'h000;
        if (x_act[i]) begin
          if (md == 1)      x_rgb[i] = solid_rgb;
          else if (md == 2) x_rgb[i] = PAL[h / (HA / 8)];
          else if (pix_valid) x_rgb[i] = fetch(s);
          else              x_uf[i] = 1'b1;
        end
      end
      m_k[i]++;
    end
    m_e[i]++;
    m_ce[i] = (m_e[i] % CFG_DIV[i] == 0);
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("rgb", i, {r[i], g[i], b[i]}, x_rgb[i]);
      chk("hsync", i, hs[i], x_hs[i]);
      chk("vsync", i, vs[i], x_vs[i]);
      chk("active", i, act[i], x_act[i]);
      chk("frame_start", i, fs[i], x_fs[i]);
      chk("underflow", i, uf[i], x_uf[i]);
      chk("pix_ce", i, pce[i], m_ce[i]);
      chk("pix_x", i, px[i], m_k[i] % HT);
      chk("pix_y", i, py[i], (m_k[i] / HT) % VT);
      chk("pix_req", i, preq[i], !rst && in_act(m_k[i]));
      if (fs[i] === 1'b1) begin
        if (last_fs[i] >= 0)
          chk("frame_period", i, cyc - last_fs[i], CFG_DIV[i] * FT);
        last_fs[i] = cyc;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    @(negedge clk);
    check_all();
    pd[0] = fetch(m_k[0] - CFG_LAT[0]);
    pd[1] = fetch(m_k[1] - CFG_LAT[1]);
  endtask

  initial begin
    bit got [2];
    int at [2];

    tab[0]  = '{12'hFFF, 1'b1, 1'b1};
    tab[1]  = '{12'hFF0, 1'b1, 1'b1};
    tab[2]  = '{12'h0FF, 1'b1, 1'b1};
    tab[3]  = '{12'h0F0, 1'b1, 1'b1};
    tab[4]  = '{12'hF0F, 1'b1, 1'b1};
    tab[5]  = '{12'hF00, 1'b1, 1'b1};
    tab[6]  = '{12'h00F, 1'b1, 1'b1};
    tab[7]  = '{12'h000, 1'b1, 1'b1};
    tab[8]  = '{12'h000, 1'b1, 1'b0};
    tab[9]  = '{12'h000, 1'b1, 1'b0};
    tab[10] = '{12'h000, 1'b0, 1'b0};
    tab[11] = '{12'h000, 1'b0, 1'b0};
    tab[12] = '{12'h000, 1'b1, 1'b0};
    tab[13] = '{12'h000, 1'b1, 1'b0};

    rst = 1'b1; mode = 2'd0; solid_rgb = 12'h000; pix_valid = 1'b1;
    pd[0] = fetch(0); pd[1] = fetch(-2);
    repeat (3) step();

    // First line of colour bars on the unit-divider instance
    mode = 2'd2;
    rst = 1'b0;
    step();
    for (int n = 0; n < 14; n++) begin
      step();
      chk("tab_rgb", n, {r[0], g[0], b[0]}, tab[n].rgb);
      chk("tab_hsync", n, hs[0], tab[n].hs);
      chk("tab_active", n, act[0], tab[n].act);
    end

    for (int n = 0; n < 900; n++) begin
      pix_valid = ($urandom_range(7) != 0);
      solid_rgb = 12'($urandom);
      if ($urandom_range(63) == 0) mode = 2'($urandom);
      step();
    end

    // Mid-frame mode change and a single dropped pixel
    mode = 2'd0; pix_valid = 1'b1;
    step();
    while (m_k[0] % FT != 0) step();
    repeat (5) step();
    mode = 2'd1; solid_rgb = 12'hC80;
    while (m_k[0] % FT != HT + 2) step();
    pix_valid = 1'b0;
    step();
    chk("drop_underflow", 0, uf[0], 1);
    chk("drop_rgb", 0, {r[0], g[0], b[0]}, 12'h000);
    pix_valid = 1'b1;
    got[0] = 1'b0;
    for (int n = 0; n < 2 * FT && !got[0]; n++) begin
      step();
      if (fs[0] === 1'b1) got[0] = 1'b1;
    end
    chk("next_frame_seen", 0, got[0], 1);
    if (got[0]) chk("next_frame_solid", 0, {r[0], g[0], b[0]}, 12'hC80);

    // Reset at (5,2), then restart from the origin
    while (m_k[0] % FT != 2 * HT + 5) step();
    rst = 1'b1;
    step();
    chk("rst_hsync", 0, hs[0], 1);
    chk("rst_hsync", 1, hs[1], 0);
    chk("rst_active", 0, act[0], 0);
    chk("rst_rgb", 0, {r[0], g[0], b[0]}, 12'h000);
    chk("rst_pix_x", 0, px[0], 0);
    chk("rst_pix_req", 0, preq[0], 0);
    rst = 1'b0;
    got = '{1'b0, 1'b0};
    at = '{0, 0};
    for (int n = 1; n <= 20 && !(got[0] && got[1]); n++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (!got[i] && fs[i] === 1'b1) begin
          got[i] = 1'b1;
          at[i] = n;
        end
    end
    chk("restart_delay", 0, at[0], 2);
    chk("restart_delay", 1, at[1], 10);

    for (int n = 0; n < 400; n++) begin
      pix_valid = ($urandom_range(5) != 0);
      solid_rgb = 12'($urandom);
      if ($urandom_range(31) == 0) mode = 2'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
